// File: rtl/lanes_descrambler_pkg.sv
// Shared constants and helpers for the two-lane descrambler.
// Covers generation codes, lane seeds, the LFSR tap mask and per-generation word geometry.
package lanes_descrambler_pkg;

    typedef enum logic [1:0] {
        GEN_8    = 2'b00,
        GEN_132  = 2'b01,
        GEN_66   = 2'b10,
        GEN_RSVD = 2'b11
    } gen_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SYNC = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    localparam int WORD_W = 132;
    localparam int LFSR_W = 23;

    localparam logic [LFSR_W-1:0] SEED_L0  = 23'h1DBFBC;
    localparam logic [LFSR_W-1:0] SEED_L1  = 23'h0607BB;
    // Taps at bits 22, 20, 15, 7, 4 and 1 (x^23+x^21+x^16+x^8+x^5+x^2+1).
    localparam logic [LFSR_W-1:0] TAP_MASK = 23'h508092;

    localparam int NBITS_8   = 8;
    localparam int NBITS_132 = 128;
    localparam int NBITS_66  = 64;
    localparam int HDR_8     = 0;
    localparam int HDR_132   = 4;
    localparam int HDR_66    = 2;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
    endfunction

    // The reserved code 11 behaves exactly like the 8-bit mode.
    function automatic gen_t norm_gen(input logic [1:0] g);
        return (g == 2'b11) ? GEN_8 : gen_t'(g);
    endfunction

endpackage

// File: rtl/lanes_descrambler_lane.sv
// One lane: seeded LFSR plus a fully unrolled keystream XOR.
// The whole word is handled in one clock.
module descr_lane
    import lanes_descrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = SEED_L0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  gen_t              gen,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] lfsr_v;

    // Header bits pass through untouched; only payload bits consume keystream.
    always_comb begin
        lfsr_v = lfsr_q;
        dout   = '0;
        case (gen)
            GEN_132: begin
                dout = din;
                for (int i = 0; i < NBITS_132; i++) begin
                    dout[HDR_132+i] = din[HDR_132+i] ^ lfsr_v[LFSR_W-1];
                    lfsr_v          = lfsr_step(lfsr_v);
                end
            end
            GEN_66: begin
                dout[HDR_66-1:0] = din[HDR_66-1:0];
                for (int i = 0; i < NBITS_66; i++) begin
                    dout[HDR_66+i] = din[HDR_66+i] ^ lfsr_v[LFSR_W-1];
                    lfsr_v         = lfsr_step(lfsr_v);
                end
            end
            default: begin
                for (int i = 0; i < NBITS_8; i++) begin
                    dout[HDR_8+NBITS_8-1-i] = din[HDR_8+NBITS_8-1-i] ^ lfsr_v[LFSR_W-1];
                    lfsr_v                  = lfsr_step(lfsr_v);
                end
            end
        endcase
        lfsr_nxt = lfsr_v;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else if (load) begin
            lfsr_q <= SEED;
        end else if (adv) begin
            lfsr_q <= lfsr_nxt;
        end
    end

endmodule

// File: rtl/lanes_descrambler.sv
// Two-lane descrambler: word strobe from a delayed boundary pulse, sequencing FSM,
// and registered lane outputs.
//
//   state  | meaning
//   IDLE   | seeds loaded, outputs cleared, boundary pipe flushed
//   SYNC   | enabled, waiting for the first word strobe
//   RUN    | locked, descrambling one word pair per strobe
module lanes_descrambler
    import lanes_descrambler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        gen_speed,
    input  logic              enable_dec,
    input  logic              descr_rst,
    input  logic [WORD_W-1:0] Lane_0_rx_in,
    input  logic [WORD_W-1:0] Lane_1_rx_in,
    output logic [WORD_W-1:0] Lane_0_rx_out,
    output logic [WORD_W-1:0] Lane_1_rx_out,
    output logic              rx_valid,
    output logic              descr_locked
);

    state_t            state_q;
    gen_t              gen_q;
    gen_t              gen_n;
    logic [2:0]        pipe_q;
    logic              strb;
    logic              gen_chg;
    logic              go_idle;
    logic              active;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic [WORD_W-1:0] dout_0;
    logic [WORD_W-1:0] dout_1;

    assign gen_n     = norm_gen(gen_speed);
    assign gen_chg   = (gen_n != gen_q);
    assign go_idle   = !enable_dec || gen_chg;
    assign strb      = pipe_q[2] & enable_dec;
    assign active    = (state_q != S_IDLE);
    assign lfsr_load = go_idle || !active;
    // A strobe that coincides with a drop to IDLE is discarded, LFSR included.
    assign lfsr_adv  = strb && active && !go_idle;

    descr_lane #(.SEED(SEED_L0)) u_lane_0 (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .adv  (lfsr_adv),
        .gen  (gen_n),
        .din  (Lane_0_rx_in),
        .dout (dout_0)
    );

    descr_lane #(.SEED(SEED_L1)) u_lane_1 (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .adv  (lfsr_adv),
        .gen  (gen_n),
        .din  (Lane_1_rx_in),
        .dout (dout_1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            gen_q         <= GEN_8;
            pipe_q        <= '0;
            Lane_0_rx_out <= '0;
            Lane_1_rx_out <= '0;
            rx_valid      <= 1'b0;
            descr_locked  <= 1'b0;
        end else begin
            gen_q    <= gen_n;
            rx_valid <= 1'b0;
            // Pulses seen while idle never reach the strobe.
            if (state_q == S_IDLE) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= {pipe_q[1:0], descr_rst};
            end

            if (go_idle) begin
                state_q       <= S_IDLE;
                Lane_0_rx_out <= '0;
                Lane_1_rx_out <= '0;
                descr_locked  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q      <= S_SYNC;
                        descr_locked <= 1'b0;
                    end
                    S_SYNC, S_RUN: begin
                        if (strb) begin
                            Lane_0_rx_out <= dout_0;
                            Lane_1_rx_out <= dout_1;
                            rx_valid      <= 1'b1;
                            state_q       <= S_RUN;
                            descr_locked  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q      <= S_IDLE;
                        descr_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lanes_descrambler.sv
// Directed bench for lanes_descrambler with an independent scrambler model.
module tb_lanes_descrambler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   gen_speed = 2'b01;
    logic         enable_dec = 1'b0;
    logic         descr_rst = 1'b0;
    logic [131:0] Lane_0_rx_in = '0;
    logic [131:0] Lane_1_rx_in = '0;
    logic [131:0] Lane_0_rx_out;
    logic [131:0] Lane_1_rx_out;
    logic         rx_valid;
    logic         descr_locked;

    int total = 0;
    int bad   = 0;

    logic [22:0] m0, m1;

    always #5 clk = ~clk;

    lanes_descrambler dut (
        .clk           (clk),
        .rst           (rst),
        .gen_speed     (gen_speed),
        .enable_dec    (enable_dec),
        .descr_rst     (descr_rst),
        .Lane_0_rx_in  (Lane_0_rx_in),
        .Lane_1_rx_in  (Lane_1_rx_in),
        .Lane_0_rx_out (Lane_0_rx_out),
        .Lane_1_rx_out (Lane_1_rx_out),
        .rx_valid      (rx_valid),
        .descr_locked  (descr_locked)
    );

    task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [131:0] rand132();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[131:0];
    endfunction

    // Keystream laid out at the bit positions it is applied to.
    task automatic keystream(input logic [1:0] g, input logic [22:0] lf_in,
                             output logic [131:0] ks, output logic [22:0] lf_out);
        logic [22:0] lf;
        logic        fb;
        int          n;
        ks = '0;
        lf = lf_in;
        n  = (g == 2'b01) ? 128 : (g == 2'b10) ? 64 : 8;
        for (int i = 0; i < n; i++) begin
            case (g)
                2'b01:   ks[4+i] = lf[22];
                2'b10:   ks[2+i] = lf[22];
                default: ks[7-i] = lf[22];
            endcase
            fb = lf[22] ^ lf[20] ^ lf[15] ^ lf[7] ^ lf[4] ^ lf[1];
            lf = {lf[21:0], fb};
        end
        lf_out = lf;
    endtask

    // Pulse in cycle t, word presented in t+3, result checked in t+4.
    task automatic send_word(input string tag, input logic [131:0] in0, input logic [131:0] in1,
                             input logic [131:0] exp0, input logic [131:0] exp1);
        descr_rst = 1'b1;
        tick;
        descr_rst = 1'b0;
        tick;
        tick;
        chk({tag, "_novalid_early"}, 132'(rx_valid), 132'd0);
        Lane_0_rx_in = in0;
        Lane_1_rx_in = in1;
        tick;
        chk({tag, "_valid"}, 132'(rx_valid), 132'd1);
        chk({tag, "_lane0"}, Lane_0_rx_out, exp0);
        chk({tag, "_lane1"}, Lane_1_rx_out, exp1);
    endtask

    initial begin
        logic [131:0] ks0, ks1, raw0, raw1;
        logic [63:0]  p0, p1;
        logic [7:0]   b0, b1;
        int           pulses;

        // Reset held with live-looking inputs.
        enable_dec   = 1'b1;
        descr_rst    = 1'b1;
        Lane_0_rx_in = rand132();
        Lane_1_rx_in = rand132();
        repeat (3) tick;
        chk("rst_lane0", Lane_0_rx_out, '0);
        chk("rst_lane1", Lane_1_rx_out, '0);
        chk("rst_valid", 132'(rx_valid), 132'd0);
        chk("rst_locked", 132'(descr_locked), 132'd0);

        // Release with decoding disabled; a pulse now must be flushed.
        enable_dec = 1'b0;
        descr_rst  = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        descr_rst = 1'b1;
        tick;
        descr_rst  = 1'b0;
        enable_dec = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (rx_valid) pulses++;
        end
        chk("flush_no_strb", 132'(pulses), 132'd0);
        chk("sync_not_locked", 132'(descr_locked), 132'd0);

        // Gen 01, all-zero input: outputs are the raw keystream.
        m0 = 23'h1DBFBC;
        m1 = 23'h0607BB;
        keystream(2'b01, m0, ks0, m0);
        keystream(2'b01, m1, ks1, m1);
        send_word("g01_zero", '0, '0, ks0, ks1);
        chk("g01_locked", 132'(descr_locked), 132'd1);
        tick;
        chk("g01_valid_pulse", 132'(rx_valid), 132'd0);
        chk("g01_hold", Lane_0_rx_out, ks0);
        keystream(2'b01, m0, ks0, m0);
        keystream(2'b01, m1, ks1, m1);
        raw0 = rand132();
        raw1 = rand132();
        send_word("g01_word2", raw0 ^ ks0, raw1 ^ ks1, raw0, raw1);

        // Gen 10: speed change drops to IDLE, then SYNC with fresh seeds.
        gen_speed = 2'b10;
        tick;
        chk("g10_idle_unlocked", 132'(descr_locked), 132'd0);
        chk("g10_idle_clear", Lane_0_rx_out, '0);
        tick;
        m0 = 23'h1DBFBC;
        m1 = 23'h0607BB;
        for (int w = 0; w < 10; w++) begin
            p0 = {$urandom, $urandom};
            p1 = {$urandom, $urandom};
            keystream(2'b10, m0, ks0, m0);
            keystream(2'b10, m1, ks1, m1);
            raw0 = rand132();
            raw1 = rand132();
            raw0[65:0] = {p0, 2'b01};
            raw1[65:0] = {p1, 2'b01};
            send_word($sformatf("g10_w%0d", w), raw0 ^ ks0, raw1 ^ ks1,
                      {66'd0, p0, 2'b01}, {66'd0, p1, 2'b01});
        end

        // Gen 00: 16 bytes per lane, upper input bits are noise.
        gen_speed = 2'b00;
        tick;
        tick;
        m0 = 23'h1DBFBC;
        m1 = 23'h0607BB;
        for (int w = 0; w < 16; w++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            keystream(2'b00, m0, ks0, m0);
            keystream(2'b00, m1, ks1, m1);
            raw0 = rand132();
            raw1 = rand132();
            raw0[7:0] = b0;
            raw1[7:0] = b1;
            send_word($sformatf("g00_w%0d", w), raw0 ^ ks0, raw1 ^ ks1,
                      {124'd0, b0}, {124'd0, b1});
        end

        // One-cycle enable drop mid-stream.
        enable_dec = 1'b0;
        tick;
        chk("endrop_lane0", Lane_0_rx_out, '0);
        chk("endrop_lane1", Lane_1_rx_out, '0);
        chk("endrop_locked", 132'(descr_locked), 132'd0);
        enable_dec = 1'b1;
        tick;
        m0 = 23'h1DBFBC;
        m1 = 23'h0607BB;
        keystream(2'b00, m0, ks0, m0);
        keystream(2'b00, m1, ks1, m1);
        send_word("endrop_reseed", {124'd0, 8'hA5} ^ ks0, {124'd0, 8'h3C} ^ ks1,
                  {124'd0, 8'hA5}, {124'd0, 8'h3C});

        // Gen 01 word, then a speed change landing on the strobe cycle.
        gen_speed = 2'b01;
        tick;
        tick;
        m0 = 23'h1DBFBC;
        m1 = 23'h0607BB;
        keystream(2'b01, m0, ks0, m0);
        keystream(2'b01, m1, ks1, m1);
        raw0 = rand132();
        raw1 = rand132();
        send_word("pre_chg", raw0 ^ ks0, raw1 ^ ks1, raw0, raw1);
        descr_rst = 1'b1;
        tick;
        descr_rst = 1'b0;
        tick;
        tick;
        gen_speed    = 2'b10;
        Lane_0_rx_in = rand132();
        Lane_1_rx_in = rand132();
        tick;
        chk("chg_no_valid", 132'(rx_valid), 132'd0);
        chk("chg_unlocked", 132'(descr_locked), 132'd0);
        chk("chg_lane0_clear", Lane_0_rx_out, '0);
        chk("chg_lane1_clear", Lane_1_rx_out, '0);
        tick;
        m0 = 23'h1DBFBC;
        m1 = 23'h0607BB;
        p0 = 64'h0123_4567_89AB_CDEF;
        p1 = 64'hFEDC_BA98_7654_3210;
        keystream(2'b10, m0, ks0, m0);
        keystream(2'b10, m1, ks1, m1);
        send_word("post_chg", {66'd0, p0, 2'b01} ^ ks0, {66'd0, p1, 2'b01} ^ ks1,
                  {66'd0, p0, 2'b01}, {66'd0, p1, 2'b01});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
